// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: post-reset fill, LSU wait
// states with timeout, load-use bubbles and taken-branch redirects, plus perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_i,
  input  logic             ex_is_load_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             mem_wb_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_err_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [INIT_W-1:0] init_q, init_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              stall_inc, flush_inc;

  logic memstall, loaduse, rs1_hit, rs2_hit, timeout, stall_now;

  assign memstall = mem_req_i & ~dmem_ready_i;
  assign rs1_hit  = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit  = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
  assign loaduse  = ex_is_load_i & ex_rd_wren_i & (ex_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit);

  // The MEM_TIMEOUT-th consecutive wait cycle is released as if the LSU were ready.
  assign timeout   = (state_q == ST_MEM_WAIT) & memstall & (wait_q >= WAIT_LAST);
  assign stall_now = memstall & ~timeout;

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b1;
    id_ex_flush_o  = 1'b0;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    mem_wb_flush_o = 1'b0;
    state_d        = state_q;
    init_d         = init_q;
    wait_d         = wait_q;
    err_d          = err_q;
    flush_inc      = 1'b0;

    case (state_q)
      ST_INIT: begin
        pc_en_o        = 1'b0;
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        mem_wb_flush_o = 1'b1;
        if (init_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          init_d = init_q + INIT_W'(1);
        end
      end

      default: begin
        if (timeout) begin
          err_d = 1'b1;
        end

        if (stall_now) begin
          pc_en_o        = 1'b0;
          if_id_en_o     = 1'b0;
          id_ex_en_o     = 1'b0;
          ex_mem_en_o    = 1'b0;
          mem_wb_flush_o = 1'b1;
          state_d        = ST_MEM_WAIT;
          wait_d         = (state_q == ST_MEM_WAIT) ? wait_q + WAIT_W'(1) : WAIT_W'(1);
        end else begin
          state_d = ST_RUN;
          wait_d  = '0;
          // Branch outranks load-use: the dependent instruction in ID is killed anyway.
          if (ex_br_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            flush_inc     = 1'b1;
          end else if (loaduse) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
      end
    endcase
  end

  assign stall_inc = (state_q != ST_INIT) & ~pc_en_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (stall_inc) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o   = stall_q;
  assign flush_cnt_o   = flush_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle-level reference model queues the
// expected response per driven cycle; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 32;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush}
  localparam logic [7:0] CTRL_INIT     = 8'b0111_1111;
  localparam logic [7:0] CTRL_MEMSTALL = 8'b0000_0011;
  localparam logic [7:0] CTRL_BRANCH   = 8'b1111_1110;
  localparam logic [7:0] CTRL_LOADUSE  = 8'b0001_1110;
  localparam logic [7:0] CTRL_NORMAL   = 8'b1101_0110;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       rd_wren;
    logic       is_load;
    logic       br_taken;
    logic       mem_req;
    logic       dmem_ready;
  } stim_t;

  typedef struct packed {
    logic [7:0]       ctrl;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             err;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             reset_ni = 1'b0;
  logic [4:0]       id_rs1_addr_i = '0, id_rs2_addr_i = '0, ex_rd_addr_i = '0;
  logic             id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
  logic             ex_rd_wren_i = 1'b0, ex_is_load_i = 1'b0, ex_br_taken_i = 1'b0;
  logic             mem_req_i = 1'b0, dmem_ready_i = 1'b0;
  logic             pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o;
  logic             ex_mem_en_o, mem_wb_en_o, mem_wb_flush_o, timeout_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [7:0]       ctrl_vec;

  pipe_hazard_ctrl #(
    .INIT_CYCLES(INIT_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_rd_wren_i  (ex_rd_wren_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_br_taken_i (ex_br_taken_i),
    .mem_req_i     (mem_req_i),
    .dmem_ready_i  (dmem_ready_i),
    .pc_en_o       (pc_en_o),
    .if_id_en_o    (if_id_en_o),
    .if_id_flush_o (if_id_flush_o),
    .id_ex_en_o    (id_ex_en_o),
    .id_ex_flush_o (id_ex_flush_o),
    .ex_mem_en_o   (ex_mem_en_o),
    .mem_wb_en_o   (mem_wb_en_o),
    .mem_wb_flush_o(mem_wb_flush_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o),
    .timeout_err_o (timeout_err_o)
  );

  assign ctrl_vec = {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
                     ex_mem_en_o, mem_wb_en_o, mem_wb_flush_o};

  always #5 clk_i = ~clk_i;

  // Reference model state: cycles of fill left, length of the current wait run.
  int               init_left = 0;
  int               wait_len  = 0;
  logic             m_err     = 1'b0;
  logic [CNT_W-1:0] m_stall   = '0;
  logic [CNT_W-1:0] m_flush   = '0;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("sb_ctrl",      CNT_W'(ctrl_vec),      CNT_W'(mon_e.ctrl));
      check("sb_stall_cnt", stall_cnt_o,           mon_e.stall_cnt);
      check("sb_flush_cnt", flush_cnt_o,           mon_e.flush_cnt);
      check("sb_timeout",   CNT_W'(timeout_err_o), CNT_W'(mon_e.err));
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.dmem_ready = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_rs1_addr_i = s.rs1;
    id_rs2_addr_i = s.rs2;
    id_rs1_used_i = s.rs1_used;
    id_rs2_used_i = s.rs2_used;
    ex_rd_addr_i  = s.rd;
    ex_rd_wren_i  = s.rd_wren;
    ex_is_load_i  = s.is_load;
    ex_br_taken_i = s.br_taken;
    mem_req_i     = s.mem_req;
    dmem_ready_i  = s.dmem_ready;
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      reset_ni = 1'b0;
      apply(idle());
    end
    init_left = INIT_CYCLES;
    wait_len  = 0;
    m_err     = 1'b0;
    m_stall   = '0;
    m_flush   = '0;
  endtask

  // One active cycle: drive inputs, predict the response, queue it.
  task automatic drive(input stim_t s);
    exp_t       e;
    logic [7:0] c;
    bit         ms, lu;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    apply(s);
    e.stall_cnt = m_stall;
    e.flush_cnt = m_flush;
    e.err       = m_err;
    if (init_left > 0) begin
      c = CTRL_INIT;
      init_left--;
    end else begin
      ms = s.mem_req && !s.dmem_ready;
      lu = s.is_load && s.rd_wren && (s.rd != 0) &&
           ((s.rs1_used && s.rs1 == s.rd) || (s.rs2_used && s.rs2 == s.rd));
      if (ms) begin
        wait_len++;
        if (wait_len == MEM_TIMEOUT) begin
          m_err    = 1'b1;
          ms       = 1'b0;
          wait_len = 0;
        end
      end else begin
        wait_len = 0;
      end
      if (ms)              c = CTRL_MEMSTALL;
      else if (s.br_taken) begin c = CTRL_BRANCH; m_flush++; end
      else if (lu)         c = CTRL_LOADUSE;
      else                 c = CTRL_NORMAL;
      if (!c[7]) m_stall++;
    end
    e.ctrl = c;
    sb_q.push_back(e);
  endtask

  task automatic start_clean();
    do_reset(2);
    repeat (INIT_CYCLES) drive(idle());
  endtask

  function automatic stim_t mk_loaduse(input logic [4:0] rd);
    stim_t s;
    s = idle();
    s.is_load  = 1'b1;
    s.rd_wren  = 1'b1;
    s.rd       = rd;
    s.rs2_used = 1'b1;
    s.rs2      = rd;
    return s;
  endfunction

  function automatic stim_t mk_memstall();
    stim_t s;
    s = idle();
    s.mem_req    = 1'b1;
    s.dmem_ready = 1'b0;
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    int    burst;

    // Fill after reset: four flushed cycles, then a normal cycle with clear counters.
    do_reset(2);
    for (int i = 0; i < INIT_CYCLES; i++) begin
      drive(idle());
      @(negedge clk_i);
      check("init_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_INIT));
    end
    drive(idle());
    @(negedge clk_i);
    check("fill_done_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_NORMAL));
    check("fill_done_stall", stall_cnt_o, '0);

    // Load-use on rs2, then the same pattern with rd=x0.
    drive(mk_loaduse(5'd5));
    @(negedge clk_i);
    check("loaduse_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_LOADUSE));
    drive(mk_loaduse(5'd0));
    @(negedge clk_i);
    check("loaduse_x0_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_NORMAL));
    check("loaduse_stall", stall_cnt_o, 32'd1);

    // Three wait states, release on the fourth cycle.
    start_clean();
    repeat (3) drive(mk_memstall());
    s = mk_memstall();
    s.dmem_ready = 1'b1;
    drive(s);
    @(negedge clk_i);
    check("mem_release_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_NORMAL));
    drive(idle());
    @(negedge clk_i);
    check("mem_stall_cnt", stall_cnt_o, 32'd3);
    check("mem_no_timeout", CNT_W'(timeout_err_o), '0);

    // Branch held through a two-cycle memstall acts only on release.
    start_clean();
    s = mk_memstall();
    s.br_taken = 1'b1;
    drive(s);
    @(negedge clk_i);
    check("br_in_stall_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_MEMSTALL));
    drive(s);
    s.dmem_ready = 1'b1;
    drive(s);
    @(negedge clk_i);
    check("br_release_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_BRANCH));
    drive(idle());
    @(negedge clk_i);
    check("br_flush_cnt", flush_cnt_o, 32'd1);

    // Branch and load-use together: branch wins, no stall.
    start_clean();
    s = mk_loaduse(5'd7);
    s.br_taken = 1'b1;
    drive(s);
    @(negedge clk_i);
    check("br_lu_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_BRANCH));
    drive(idle());
    @(negedge clk_i);
    check("br_lu_stall", stall_cnt_o, '0);

    // Timeout on the MEM_TIMEOUT-th wait cycle, then reset mid-wait.
    start_clean();
    repeat (MEM_TIMEOUT - 1) drive(mk_memstall());
    drive(mk_memstall());
    @(negedge clk_i);
    check("timeout_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_NORMAL));
    drive(mk_memstall());
    @(negedge clk_i);
    check("timeout_err_set", CNT_W'(timeout_err_o), 32'd1);
    check("timeout_restall", CNT_W'(ctrl_vec), CNT_W'(CTRL_MEMSTALL));
    drive(mk_memstall());
    do_reset(1);
    drive(idle());
    @(negedge clk_i);
    check("reset_mid_wait_ctrl", CNT_W'(ctrl_vec), CNT_W'(CTRL_INIT));
    check("reset_mid_wait_err", CNT_W'(timeout_err_o), '0);

    // Randomized traffic with stall bursts long enough to hit the timeout.
    start_clean();
    burst = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 2));
        burst = 0;
      end
      s.rs1        = 5'($urandom_range(0, 3));
      s.rs2        = 5'($urandom_range(0, 3));
      s.rs1_used   = 1'($urandom_range(0, 1));
      s.rs2_used   = 1'($urandom_range(0, 1));
      s.rd         = 5'($urandom_range(0, 3));
      s.rd_wren    = 1'($urandom_range(0, 3) != 0);
      s.is_load    = 1'($urandom_range(0, 1));
      s.br_taken   = 1'($urandom_range(0, 5) == 0);
      if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 12);
      if (burst > 0) begin
        burst--;
        s.mem_req    = 1'b1;
        s.dmem_ready = 1'b0;
      end else begin
        s.mem_req    = 1'($urandom_range(0, 1));
        s.dmem_ready = 1'($urandom_range(0, 4) != 0);
      end
      drive(s);
    end

    repeat (3) @(negedge clk_i);
    check("sb_drained", CNT_W'(sb_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
